support_req_arbiter: RTL and testbench

// - Arbitrates reset/halt requests from NREQ sources (OSD, keyboard, debug UART) onto the support block's button_r/button_h inputs.
// - Holds the winning button long enough to pass the support block's press detection (10 samples, one per 4096 sysclk).
// - Confirms a reset took effect by watching cpu_reset, then enforces a cooldown before the next grant.

---
 rtl/support_req_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_support_req_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/support_req_arbiter.sv
// ---------------------------------------------------------------------------
// support_req_arbiter
//
// Purpose:
//   Arbitrates reset and halt requests from NREQ sources (OSD, keyboard,
//   debug UART) onto the support block's button_r / button_h inputs. The
//   winning button is held long enough to pass the support block's press
//   detection. A reset grant is confirmed by watching cpu_reset rise and
//   fall. Every grant is followed by a cooldown before the next one.
//
// Optional feature:
//   SUPPORT_ARB_RR_EN  when defined, sources within a class are picked
//                      round-robin from rr_ptr. rr_ptr is shared by the
//                      reset and halt classes. When undefined, the lowest
//                      requesting index wins and rr_ptr does not exist.
//
// Ports:
//   sysclk     in   1     clock
//   reset_n    in   1     asynchronous active-low reset
//   req_reset  in   NREQ  per-source reset request, level, held until ack
//   req_halt   in   NREQ  per-source halt request, level, held until ack
//   cpu_reset  in   1     reset output of the support block (sysclk domain)
//   ack        out  NREQ  one-cycle pulse to the granted source on completion
//   button_r   out  1     to support block button_r
//   button_h   out  1     to support block button_h
//   busy       out  1     high in any state other than IDLE
//   err        out  1     sticky, set when a reset grant times out
// ---------------------------------------------------------------------------
module support_req_arbiter #(
    parameter int NREQ            = 3,
    parameter int HOLD_CYCLES     = 45056,
    parameter int COOLDOWN_CYCLES = 8192,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int CNT_W           = 17
) (
    input  logic            sysclk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req_reset,
    input  logic [NREQ-1:0] req_halt,
    input  logic            cpu_reset,
    output logic [NREQ-1:0] ack,
    output logic            button_r,
    output logic            button_h,
    output logic            busy,
    output logic            err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_RISE,
        ST_WAIT_FALL,
        ST_COOLDOWN
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   g_q;
    logic               is_reset_q;
    logic [NREQ-1:0]    ack_q;
    logic               button_r_q;
    logic               button_h_q;
    logic               busy_q;
    logic               err_q;

    logic [NREQ-1:0]    class_req;
    logic               sel_valid;
    logic [IDX_W-1:0]   g_d;
    logic               is_reset_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NREQ-1:0]    ack_d;

`ifdef SUPPORT_ARB_RR_EN
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;
    int                 rr_idx;
`endif

    // The reset class wins outright whenever any reset request is present,
    // so the source search only ever looks at one class vector.
    always_comb begin
        is_reset_d = |req_reset;
        class_req  = is_reset_d ? req_reset : req_halt;
        sel_valid  = 1'b0;
        g_d        = '0;
`ifdef SUPPORT_ARB_RR_EN
        rr_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (!sel_valid && class_req[IDX_W'(rr_idx)]) begin
                sel_valid = 1'b1;
                g_d       = IDX_W'(rr_idx);
            end
        end
        rr_ptr_d = (g_d == IDX_W'(NREQ - 1)) ? '0 : g_d + 1'b1;
`else
        // Scanning from the top lets the lowest set index overwrite last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (class_req[k]) begin
                sel_valid = 1'b1;
                g_d       = IDX_W'(k);
            end
        end
`endif
    end

    // The counter saturates at all-ones rather than wrapping, so a
    // mis-sized CNT_W stalls visibly instead of silently restarting.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign ack_d   = NREQ'(1) << g_q;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            g_q        <= '0;
            is_reset_q <= 1'b0;
            ack_q      <= '0;
            button_r_q <= 1'b0;
            button_h_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SUPPORT_ARB_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        g_q        <= g_d;
                        is_reset_q <= is_reset_d;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        button_r_q <= is_reset_d;
                        button_h_q <= !is_reset_d;
                        state_q    <= ST_ASSERT;
`ifdef SUPPORT_ARB_RR_EN
                        rr_ptr_q   <= rr_ptr_d;
`endif
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        button_r_q <= 1'b0;
                        button_h_q <= 1'b0;
                        cnt_q      <= '0;
                        if (is_reset_q) begin
                            state_q <= ST_WAIT_RISE;
                        end else begin
                            ack_q   <= ack_d;
                            state_q <= ST_COOLDOWN;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_WAIT_RISE: begin
                    if (cpu_reset) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_FALL;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_q   <= 1'b1;
                        ack_q   <= ack_d;
                        cnt_q   <= '0;
                        state_q <= ST_COOLDOWN;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_WAIT_FALL: begin
                    if (!cpu_reset) begin
                        ack_q   <= ack_d;
                        cnt_q   <= '0;
                        state_q <= ST_COOLDOWN;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_q   <= 1'b1;
                        ack_q   <= ack_d;
                        cnt_q   <= '0;
                        state_q <= ST_COOLDOWN;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_COOLDOWN: begin
                    // Requests are deliberately not sampled here; a source
                    // still holding its request is picked up again in IDLE.
                    if (cnt_q == COOL_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    cnt_q      <= '0;
                    button_r_q <= 1'b0;
                    button_h_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign button_r = button_r_q;
    assign button_h = button_h_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_support_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_support_req_arbiter
//
// Bench for support_req_arbiter with short hold/cooldown/timeout values.
// Expected ack values are queued when a request is applied and popped by a
// monitor whenever the DUT raises ack. The monitor also checks button
// exclusivity every cycle and measures every completed button pulse.
// ---------------------------------------------------------------------------
module tb_support_req_arbiter;

    localparam int NREQ = 3;
    localparam int HOLD = 8;
    localparam int COOL = 4;
    localparam int TMO  = 32;

    logic            sysclk    = 1'b0;
    logic            reset_n   = 1'b0;
    logic [NREQ-1:0] req_reset = '0;
    logic [NREQ-1:0] req_halt  = '0;
    logic            cpu_reset = 1'b0;
    logic [NREQ-1:0] ack;
    logic            button_r;
    logic            button_h;
    logic            busy;
    logic            err;

    int              compareCount  = 0;
    int              mismatchCount = 0;
    int              runLen        = 0;
    logic [NREQ-1:0] expAckQ[$];

    support_req_arbiter #(
        .NREQ            (NREQ),
        .HOLD_CYCLES     (HOLD),
        .COOLDOWN_CYCLES (COOL),
        .TIMEOUT_CYCLES  (TMO),
        .CNT_W           (17)
    ) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .req_reset (req_reset),
        .req_halt  (req_halt),
        .cpu_reset (cpu_reset),
        .ack       (ack),
        .button_r  (button_r),
        .button_h  (button_h),
        .busy      (busy),
        .err       (err)
    );

    // Free-running system clock, 10 time units per cycle.
    always #5 sysclk = ~sysclk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives a new request pair just after a rising edge.
    task automatic applyStimulus(input logic [NREQ-1:0] rst, input logic [NREQ-1:0] hlt);
        @(posedge sysclk);
        #1;
        req_reset = rst;
        req_halt  = hlt;
    endtask

    function automatic logic sigVal(input int which);
        case (which)
            0:       return button_r;
            1:       return button_h;
            2:       return busy;
            default: return |ack;
        endcase
    endfunction

    // Waits (on falling edges) for a DUT signal to reach a level, bounded.
    task automatic waitSignal(input string tag, input int which, input logic level,
                              input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (sigVal(which) === level) return;
        end
        checkOutput(tag, 32'(sigVal(which)), 32'(level));
    endtask

    // Models the support block: cpu_reset rises 3 cycles after button_r
    // falls and stays high for 5 cycles.
    task automatic cpuResetPulse();
        waitSignal("wait_br_rise", 0, 1'b1, 40);
        waitSignal("wait_br_fall", 0, 1'b0, 40);
        repeat (3) @(posedge sysclk);
        #1 cpu_reset = 1'b1;
        repeat (5) @(posedge sysclk);
        #1 cpu_reset = 1'b0;
    endtask

    // Scoreboard monitor: exclusivity, ack ordering, and pulse length.
    always @(negedge sysclk) begin
        checkOutput("exclusive", 32'(button_r & button_h), 32'd0);
        if (reset_n && ack !== '0) begin
            if (expAckQ.size() == 0) begin
                checkOutput("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                checkOutput("ack_sb", 32'(ack), 32'(expAckQ.pop_front()));
            end
        end
        if (!reset_n) begin
            runLen = 0;
        end else if (button_r || button_h) begin
            runLen++;
        end else if (runLen != 0) begin
            checkOutput("hold_len", 32'(runLen), 32'(HOLD));
            runLen = 0;
        end
    end

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] grantSeq[4];
        int              nGrants;

        // Reset state
        repeat (2) @(negedge sysclk);
        checkOutput("rst_button_r", 32'(button_r), 32'd0);
        checkOutput("rst_button_h", 32'(button_h), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        @(posedge sysclk);
        #1 reset_n = 1'b1;

        // Test 1: single reset request from source 1 with a normal cpu_reset pulse
        expAckQ.push_back(3'b010);
        applyStimulus(3'b010, 3'b000);
        @(negedge sysclk);
        checkOutput("t1_no_grant_yet", 32'(button_r), 32'd0);
        @(negedge sysclk);
        checkOutput("t1_button_r", 32'(button_r), 32'd1);
        checkOutput("t1_button_h", 32'(button_h), 32'd0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        cpuResetPulse();
        @(negedge sysclk);
        checkOutput("t1_ack_early", 32'(ack), 32'd0);
        @(negedge sysclk);
        checkOutput("t1_ack", 32'(ack), 32'b010);
        req_reset = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            checkOutput("t1_busy_cool", 32'(busy), 32'd1);
            checkOutput("t1_ack_once", 32'(ack), 32'd0);
        end
        @(negedge sysclk);
        checkOutput("t1_busy_low", 32'(busy), 32'd0);
        checkOutput("t1_err", 32'(err), 32'd0);

        // Test 2: reset and halt on the same cycle, reset wins
        expAckQ.push_back(3'b001);
        expAckQ.push_back(3'b100);
        applyStimulus(3'b001, 3'b100);
        cpuResetPulse();
        waitSignal("t2_ack0_wait", 3, 1'b1, 10);
        checkOutput("t2_ack0", 32'(ack), 32'b001);
        req_reset = '0;
        waitSignal("t2_bh_rise", 1, 1'b1, 20);
        checkOutput("t2_br_low", 32'(button_r), 32'd0);
        waitSignal("t2_bh_fall", 1, 1'b0, 20);
        checkOutput("t2_ack2", 32'(ack), 32'b100);
        req_halt = '0;
        waitSignal("t2_idle", 2, 1'b0, 20);

        // Test 3: cpu_reset never rises, grant times out
        expAckQ.push_back(3'b001);
        applyStimulus(3'b001, 3'b000);
        repeat (HOLD + TMO + 1) @(negedge sysclk);
        checkOutput("t3_err_before", 32'(err), 32'd0);
        checkOutput("t3_ack_before", 32'(ack), 32'd0);
        @(negedge sysclk);
        checkOutput("t3_err_set", 32'(err), 32'd1);
        checkOutput("t3_ack", 32'(ack), 32'b001);
        req_reset = '0;
        waitSignal("t3_idle", 2, 1'b0, 20);
        repeat (3) @(negedge sysclk);
        checkOutput("t3_err_sticky", 32'(err), 32'd1);

        // Test 4: reset_n mid-ASSERT, then the still-held request is regranted
        applyStimulus(3'b001, 3'b000);
        repeat (4) @(negedge sysclk);
        checkOutput("t4_in_assert", 32'(button_r), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t4_async_br", 32'(button_r), 32'd0);
        checkOutput("t4_async_busy", 32'(busy), 32'd0);
        checkOutput("t4_async_err", 32'(err), 32'd0);
        checkOutput("t4_async_ack", 32'(ack), 32'd0);
        expAckQ.push_back(3'b001);
        repeat (2) @(posedge sysclk);
        #1 reset_n = 1'b1;
        cpuResetPulse();
        waitSignal("t4_ack_wait", 3, 1'b1, 10);
        checkOutput("t4_ack", 32'(ack), 32'b001);
        req_reset = '0;
        waitSignal("t4_idle", 2, 1'b0, 20);
        checkOutput("t4_err", 32'(err), 32'd0);

        // Test 5: all sources hold reset continuously (fresh rr_ptr)
        @(posedge sysclk);
        #1 reset_n = 1'b0;
        @(posedge sysclk);
        #1 reset_n = 1'b1;
`ifdef SUPPORT_ARB_RR_EN
        grantSeq = '{3'b001, 3'b010, 3'b100, 3'b001};
        nGrants  = 4;
`else
        grantSeq = '{3'b001, 3'b001, 3'b001, 3'b001};
        nGrants  = 3;
`endif
        for (int i = 0; i < nGrants; i++) expAckQ.push_back(grantSeq[i]);
        applyStimulus(3'b111, 3'b000);
        for (int i = 0; i < nGrants; i++) begin
            cpuResetPulse();
            waitSignal("t5_ack_wait", 3, 1'b1, 10);
            checkOutput("t5_grant", 32'(ack), 32'(grantSeq[i]));
            if (i == nGrants - 1) req_reset = '0;
        end
        waitSignal("t5_idle", 2, 1'b0, 20);
        checkOutput("t5_err", 32'(err), 32'd0);

        repeat (4) @(negedge sysclk);
        checkOutput("sb_empty", 32'(expAckQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
